// File: rtl/scie_fir_seq_mac.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// scie_fir_seq_mac
//
// Sequential NTAPS-tap signed FIR reached via the SCIE custom-instruction port.
// Coefficients and the sample history are held in small register banks. One
// shared multiplier evaluates one tap per cycle under a three-state FSM
// (IDLE -> MAC -> DONE -> IDLE). The block also provides busy/status read-back,
// a history clear, and sticky error flags.
//
// Instruction decode (only while io_valid=1):
//   opcode 0x0B funct3 0 : WCOEF  coef[rs2] <= rs1[DW-1:0] (ERR if rs2>=NTAPS or busy)
//   opcode 0x0B funct3 1 : CLEAR  history, write pointer, acc, result <= 0; abort MAC
//   opcode 0x2B any      : PUSH   store sample and start a MAC run (OVF if busy)
//   opcode 0x5B funct3 0 : RDRES  io_rd <= result
//   opcode 0x5B funct3 1 : RDSTAT io_rd <= {28'b0, SAT, ERR, OVF, busy}; clears flags
//   anything else        : ignored
//
// Parameters:
//   NTAPS : number of taps, >= 2 and a power of two (ring pointer wraps freely)
//   DW    : signed coefficient/sample width, 2..32
//   AW    : accumulator width, derived as 2*DW + clog2(NTAPS)
//
// Ports:
//   clock    in   1  rising-edge clock
//   reset    in   1  synchronous active-high reset
//   io_valid in   1  io_insn/io_rs1/io_rs2 valid this cycle
//   io_insn  in  32  instruction word (opcode [6:0], funct3 [14:12])
//   io_rs1   in  32  coefficient or sample value
//   io_rs2   in  32  coefficient index
//   io_rd    out 32  registered read-back data
//   io_busy  out  1  high while a MAC run (MAC or DONE state) is in progress
//
// Optional feature macro: SCIE_FIR_SAT_EN
//   Defined   : result is clamped to signed 32-bit range; status bit3 (SAT) is a
//               sticky clamp indicator cleared by RDSTAT.
//   Undefined : result is the accumulator truncated/sign-extended to 32 bits and
//               status bit3 always reads 0.
// -----------------------------------------------------------------------------
module scie_fir_seq_mac #(
  parameter int NTAPS = 4,
  parameter int DW    = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_valid,
  input  logic [31:0] io_insn,
  input  logic [31:0] io_rs1,
  input  logic [31:0] io_rs2,
  output logic [31:0] io_rd,
  output logic        io_busy
);

  localparam int PW = $clog2(NTAPS);
  localparam int AW = 2 * DW + PW;

  localparam logic [6:0]    OP_CFG  = 7'h0B;
  localparam logic [6:0]    OP_PUSH = 7'h2B;
  localparam logic [6:0]    OP_RD   = 7'h5B;
  localparam logic [PW-1:0] K_LAST  = PW'(NTAPS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e               state_q, state_d;
  logic [PW-1:0]        k_q, k_d;
  logic [PW-1:0]        wptr_q, wptr_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic [31:0]          result_q, result_d;
  logic [31:0]          rd_q, rd_d;
  logic                 err_q, err_d;
  logic                 ovf_q, ovf_d;
  logic                 sat_flag;

  assign io_busy = (state_q != S_IDLE);
  assign io_rd   = rd_q;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       dec_wcoef;
  logic       dec_clear;
  logic       dec_push;
  logic       dec_rdres;
  logic       dec_rdstat;
  logic       rs2_in_range;
  logic       wcoef_ok;
  logic       wcoef_err;
  logic       push_ok;
  logic       push_ovf;

  assign opcode = io_insn[6:0];
  assign funct3 = io_insn[14:12];

  assign dec_wcoef  = io_valid && (opcode == OP_CFG)  && (funct3 == 3'd0);
  assign dec_clear  = io_valid && (opcode == OP_CFG)  && (funct3 == 3'd1);
  assign dec_push   = io_valid && (opcode == OP_PUSH);
  assign dec_rdres  = io_valid && (opcode == OP_RD)   && (funct3 == 3'd0);
  assign dec_rdstat = io_valid && (opcode == OP_RD)   && (funct3 == 3'd1);

  // The whole 32-bit index is compared so that e.g. rs2=NTAPS+1 is rejected
  // rather than aliasing onto a low tap.
  assign rs2_in_range = (io_rs2 < 32'(NTAPS));
  assign wcoef_ok     = dec_wcoef && rs2_in_range && !io_busy;
  assign wcoef_err    = dec_wcoef && !wcoef_ok;
  assign push_ok      = dec_push && !io_busy;
  assign push_ovf     = dec_push && io_busy;

  // Operand bits outside the decoded fields are intentionally ignored.
  logic unused_insn;
  assign unused_insn = ^{io_insn[31:15], io_insn[11:7]};

  if (DW < 32) begin : g_rs1_unused
    logic unused_rs1;
    assign unused_rs1 = ^io_rs1[31:DW];
  end

  // ---------------------------------------------------------------------------
  // Coefficient and sample register banks, one entry per tap.
  // Samples are a ring indexed by wptr_q; the newest sample sits at wptr_q-1.
  // ---------------------------------------------------------------------------
  logic signed [DW-1:0] coef_rd   [NTAPS];
  logic signed [DW-1:0] sample_rd [NTAPS];

  for (genvar gi = 0; gi < NTAPS; gi++) begin : g_tap
    logic signed [DW-1:0] coef_q;
    logic signed [DW-1:0] sample_q;

    always_ff @(posedge clock) begin
      if (reset) begin
        coef_q <= '0;
      end else if (wcoef_ok && (io_rs2[PW-1:0] == PW'(gi))) begin
        coef_q <= io_rs1[DW-1:0];
      end
    end

    always_ff @(posedge clock) begin
      if (reset || dec_clear) begin
        sample_q <= '0;
      end else if (push_ok && (wptr_q == PW'(gi))) begin
        sample_q <= io_rs1[DW-1:0];
      end
    end

    assign coef_rd[gi]   = coef_q;
    assign sample_rd[gi] = sample_q;
  end

  // ---------------------------------------------------------------------------
  // Shared multiplier: tap k pairs coef[k] with the sample k steps older than
  // the newest one. PW-bit subtraction gives the mod-NTAPS wrap for free.
  // ---------------------------------------------------------------------------
  logic [PW-1:0]          tap_idx;
  logic signed [DW-1:0]   coef_cur;
  logic signed [DW-1:0]   samp_cur;
  logic signed [2*DW-1:0] prod;

  assign tap_idx  = wptr_q - PW'(1) - k_q;
  assign coef_cur = coef_rd[k_q];
  assign samp_cur = sample_rd[tap_idx];
  assign prod     = (2*DW)'(coef_cur) * (2*DW)'(samp_cur);

  // ---------------------------------------------------------------------------
  // Result formatting
  // ---------------------------------------------------------------------------
  logic [31:0] fmt_val;
  logic        sat_hit;

`ifdef SCIE_FIR_SAT_EN
  if (AW > 32) begin : g_clamp
    // The value fits in signed 32 bits only if bits [AW-1:31] are all equal.
    logic [AW-32:0] acc_top;
    assign acc_top = acc_q[AW-1:31];
    assign sat_hit = !((&acc_top) || !(|acc_top));
    assign fmt_val = sat_hit ? (acc_q[AW-1] ? 32'h8000_0000 : 32'h7FFF_FFFF)
                             : acc_q[31:0];
  end else begin : g_noclamp
    assign sat_hit = 1'b0;
    assign fmt_val = 32'(acc_q);
  end
`else
  // Signed size cast: truncates when AW>32, sign-extends otherwise.
  assign fmt_val = 32'(acc_q);
  assign sat_hit = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM and datapath next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    wptr_d   = wptr_q;
    acc_d    = acc_q;
    result_d = result_q;

    unique case (state_q)
      S_IDLE: begin
        if (push_ok) begin
          state_d = S_MAC;
          k_d     = '0;
          acc_d   = '0;
          wptr_d  = wptr_q + PW'(1);
        end
      end
      S_MAC: begin
        acc_d = acc_q + AW'(prod);
        k_d   = k_q + PW'(1);
        if (k_q == K_LAST) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        result_d = fmt_val;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // CLEAR overrides whatever the FSM was doing; a partial sum is discarded.
    if (dec_clear) begin
      state_d  = S_IDLE;
      k_d      = '0;
      wptr_d   = '0;
      acc_d    = '0;
      result_d = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Read-back and sticky flags
  // ---------------------------------------------------------------------------
  logic status_sat;

`ifdef SCIE_FIR_SAT_EN
  logic sat_q, sat_d;
  assign status_sat = sat_q;
  assign sat_flag   = sat_q;

  always_comb begin
    sat_d = sat_q;
    if (dec_rdstat) begin
      sat_d = 1'b0;
    end
    // A clamp landing on the same edge as RDSTAT has not been reported yet,
    // so it stays pending for the next status read.
    if ((state_q == S_DONE) && sat_hit && !dec_clear) begin
      sat_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sat_q <= 1'b0;
    end else begin
      sat_q <= sat_d;
    end
  end
`else
  assign status_sat = 1'b0;
  assign sat_flag   = sat_hit;
`endif

  logic unused_sat;
  assign unused_sat = sat_flag;

  always_comb begin
    rd_d  = rd_q;
    err_d = err_q;
    ovf_d = ovf_q;

    if (dec_rdres) begin
      rd_d = result_q;
    end
    if (dec_rdstat) begin
      rd_d  = {28'b0, status_sat, err_q, ovf_q, io_busy};
      err_d = 1'b0;
      ovf_d = 1'b0;
    end
    if (wcoef_err) begin
      err_d = 1'b1;
    end
    if (push_ovf) begin
      ovf_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      wptr_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
      rd_q     <= '0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      wptr_q   <= wptr_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      rd_q     <= rd_d;
      err_q    <= err_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule

// File: tb/tb_scie_fir_seq_mac.sv
`timescale 1ns/1ps
// Self-checking bench for scie_fir_seq_mac (NTAPS=4, DW=16).
// A transaction-level reference model (coefficient array, newest-first sample
// history, busy countdown) predicts io_rd and io_busy after every clock edge.
module tb_scie_fir_seq_mac;

  localparam int NTAPS = 4;
  localparam int DW    = 16;

  localparam logic [6:0] OP_CFG  = 7'h0B;
  localparam logic [6:0] OP_PUSH = 7'h2B;
  localparam logic [6:0] OP_RD   = 7'h5B;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_valid;
  logic [31:0] io_insn;
  logic [31:0] io_rs1;
  logic [31:0] io_rs2;
  logic [31:0] io_rd;
  logic        io_busy;

  always #5 clock = ~clock;

  scie_fir_seq_mac #(.NTAPS(NTAPS), .DW(DW)) dut (
    .clock    (clock),
    .reset    (reset),
    .io_valid (io_valid),
    .io_insn  (io_insn),
    .io_rs1   (io_rs1),
    .io_rs2   (io_rs2),
    .io_rd    (io_rd),
    .io_busy  (io_busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  longint      coef_m [NTAPS];
  longint      hist_m [NTAPS];   // hist_m[0] is the newest sample x[n]
  logic [31:0] result_m;
  logic [31:0] rd_m;
  logic [31:0] pend_m;
  bit          pend_sat;
  int          busy_cnt;         // cycles of busy still to come
  bit          err_m, ovf_m, sat_m;

  // Bit 32 flags a clamp; bits [31:0] are the formatted result.
  function automatic logic [32:0] fmt32(input longint y);
    logic [63:0] yb;
`ifdef SCIE_FIR_SAT_EN
    if (y > 64'sd2147483647)  return {1'b1, 32'h7FFF_FFFF};
    if (y < -64'sd2147483648) return {1'b1, 32'h8000_0000};
`endif
    yb = y;
    return {1'b0, yb[31:0]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NTAPS; i++) begin
      coef_m[i] = 0;
      hist_m[i] = 0;
    end
    result_m = 0; rd_m = 0; pend_m = 0; pend_sat = 0;
    busy_cnt = 0; err_m = 0; ovf_m = 0; sat_m = 0;
  endtask

  task automatic model_edge(input bit v, input logic [31:0] insn,
                            input logic [31:0] rs1, input logic [31:0] rs2);
    logic [6:0]  op;
    logic [2:0]  f3;
    bit          old_busy;
    bit          tick;
    logic [31:0] old_res;
    longint      y;
    logic [32:0] f;
    op       = insn[6:0];
    f3       = insn[14:12];
    old_busy = (busy_cnt != 0);
    tick     = old_busy;
    old_res  = result_m;
    if (v) begin
      if (op == OP_CFG && f3 == 3'd0) begin
        if (rs2 >= NTAPS || old_busy) err_m = 1;
        else coef_m[rs2] = longint'($signed(rs1[DW-1:0]));
      end else if (op == OP_CFG && f3 == 3'd1) begin
        for (int i = 0; i < NTAPS; i++) hist_m[i] = 0;
        result_m = 0;
        busy_cnt = 0;
        tick     = 0;
      end else if (op == OP_PUSH) begin
        if (old_busy) ovf_m = 1;
        else begin
          for (int i = NTAPS - 1; i > 0; i--) hist_m[i] = hist_m[i-1];
          hist_m[0] = longint'($signed(rs1[DW-1:0]));
          y = 0;
          for (int i = 0; i < NTAPS; i++) y += coef_m[i] * hist_m[i];
          f        = fmt32(y);
          pend_m   = f[31:0];
          pend_sat = f[32];
          busy_cnt = NTAPS + 1;
        end
      end else if (op == OP_RD && f3 == 3'd0) begin
        rd_m = old_res;
      end else if (op == OP_RD && f3 == 3'd1) begin
        rd_m  = {28'h0, sat_m, err_m, ovf_m, old_busy};
        err_m = 0; ovf_m = 0; sat_m = 0;
      end
    end
    if (tick) begin
      busy_cnt--;
      if (busy_cnt == 0) begin
        result_m = pend_m;
        if (pend_sat) sat_m = 1;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Drivers
  // ---------------------------------------------------------------------------
  task automatic compare_outputs();
    check("rd", io_rd, rd_m);
    check("busy", 32'(io_busy), 32'(busy_cnt != 0));
  endtask

  task automatic txn(input logic [6:0] op, input logic [2:0] f3,
                     input logic [31:0] rs1, input logic [31:0] rs2);
    io_valid = 1'b1;
    io_insn  = {17'($urandom), f3, 5'($urandom), op};
    io_rs1   = rs1;
    io_rs2   = rs2;
    @(posedge clock);
    model_edge(1'b1, io_insn, rs1, rs2);
    #1;
    io_valid = 1'b0;
    compare_outputs();
    $display("txn op=%02h f3=%0d rs1=%08h rs2=%08h rd=%08h busy=%0b",
             op, f3, rs1, rs2, io_rd, io_busy);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      io_valid = 1'b0;
      @(posedge clock);
      model_edge(1'b0, io_insn, io_rs1, io_rs2);
      #1;
      compare_outputs();
    end
  endtask

  task automatic do_reset(input int n);
    reset    = 1'b1;
    io_valid = 1'b0;
    repeat (n) @(posedge clock);
    model_reset();
    #1;
    reset = 1'b0;
    compare_outputs();
  endtask

  task automatic wcoef(input int idx, input logic [31:0] val);
    txn(OP_CFG, 3'd0, val, 32'(idx));
  endtask
  task automatic push(input logic [31:0] val);  txn(OP_PUSH, 3'(
    $urandom), val, 32'($urandom)); endtask
  task automatic rdres();  txn(OP_RD, 3'd0, 32'($urandom), 32'($urandom)); endtask
  task automatic rdstat(); txn(OP_RD, 3'd1, 32'($urandom), 32'($urandom)); endtask
  task automatic clear();  txn(OP_CFG, 3'd1, 32'($urandom), 32'($urandom)); endtask

  function automatic logic [31:0] rand_val();
    int r;
    r = $urandom_range(0, 9);
    if (r < 2) return {16'($urandom), 16'h7FFF};
    if (r < 3) return {16'($urandom), 16'h8000};
    if (r < 6) return {16'($urandom), 16'($urandom_range(0, 40))};
    return $urandom;
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int          busy_len;
    logic [31:0] exp_t6;
    logic [31:0] exp_t6_stat;
    int          r;

    io_valid = 0; io_insn = 0; io_rs1 = 0; io_rs2 = 0;
    model_reset();

    // 1: reset state
    do_reset(2);
    rdstat(); check("t1_stat", io_rd, 32'h0);
    rdres();  check("t1_res", io_rd, 32'h0);
    check("t1_busy", 32'(io_busy), 32'h0);

    // 2: one-sample delay line
    wcoef(0, 0); wcoef(1, 1); wcoef(2, 0); wcoef(3, 0);
    push(28); idle(6); rdres(); check("t2_y0", io_rd, 32'd0);
    push(63); idle(6); rdres(); check("t2_y1", io_rd, 32'd28);
    push(66); idle(6); rdres(); check("t2_y2", io_rd, 32'd63);

    // 3: full convolution and busy length
    clear();
    wcoef(0, 1); wcoef(1, 2); wcoef(2, 3); wcoef(3, 4);
    for (int s = 1; s <= 4; s++) begin
      push(32'(s));
      busy_len = int'(io_busy);
      for (int c = 0; c < 5; c++) begin
        idle(1);
        busy_len += int'(io_busy);
      end
      check("t3_busy_len", 32'(busy_len), 32'd5);
    end
    rdres(); check("t3_y", io_rd, 32'd20);

    // 4: overflow on back-to-back push
    push(5); push(6); idle(6);
    rdstat(); check("t4_stat", io_rd, 32'h2);
    rdstat(); check("t4_stat2", io_rd, 32'h0);

    // 5: bad coefficient index, CLEAR mid-MAC
    wcoef(7, 32'h1234);
    rdstat(); check("t5_stat", io_rd, 32'h4);
    push(9); idle(1); clear();
    check("t5_busy", 32'(io_busy), 32'h0);
    rdres(); check("t5_res", io_rd, 32'h0);

    // 6: large positive sum
    clear();
    for (int i = 0; i < NTAPS; i++) wcoef(i, 32'h7FFF);
    for (int i = 0; i < NTAPS; i++) begin push(32'h7FFF); idle(5); end
    rdres();
`ifdef SCIE_FIR_SAT_EN
    exp_t6 = 32'h7FFF_FFFF; exp_t6_stat = 32'h8;
`else
    exp_t6 = 32'hFFFC_0004; exp_t6_stat = 32'h0;
`endif
    check("t6_y", io_rd, exp_t6);
    rdstat(); check("t6_stat", io_rd, exp_t6_stat);

    // Randomized mix against the model
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 99);
      if      (r < 20) wcoef($urandom_range(0, 5), rand_val());
      else if (r < 50) push(rand_val());
      else if (r < 62) rdres();
      else if (r < 72) rdstat();
      else if (r < 75) clear();
      else if (r < 79) txn(OP_CFG, 3'($urandom_range(2, 7)), $urandom, $urandom);
      else if (r < 82) txn(OP_RD, 3'($urandom_range(2, 7)), $urandom, $urandom);
      else if (r < 84) txn(7'h33, 3'($urandom), $urandom, $urandom);
      else if (r < 99) idle($urandom_range(1, 6));
      else             do_reset(1);
    end
    idle(8);
    rdres();
    rdstat();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
